// File: rtl/thunderbird_pkg.sv
// Shared definitions for the thunderbird tail-light front end and sequencer.
//   tb_state_e      : turn controller FSM state encoding
//   *_DEFAULT       : parameter defaults (the sequencer reuses SEQ_STEPS_DEFAULT)
//   cw()            : counter width helper, never narrower than one bit
//   state_lamps()   : {left, right} command decoded from a controller state
package thunderbird_pkg;

  localparam int unsigned DEBOUNCE_CYC_DEFAULT = 4;
  localparam int unsigned STEP_DIV_DEFAULT     = 4;
  localparam int unsigned SEQ_STEPS_DEFAULT    = 4;
  localparam int unsigned TAP_SWEEPS_DEFAULT   = 3;
  localparam int unsigned TAP_MAX_CYC_DEFAULT  = 16;

  typedef enum logic [2:0] {
    StIdle,
    StLeft,
    StRight,
    StHazard,
    StTapL,
    StTapR
  } tb_state_e;

  // Width of a counter holding values 0..n-1.
  function automatic int unsigned cw(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [1:0] state_lamps(input tb_state_e st);
    logic [1:0] lamps;
    lamps = 2'b00;
    case (st)
      StLeft, StTapL:  lamps = 2'b10;
      StRight, StTapR: lamps = 2'b01;
      StHazard:        lamps = 2'b11;
      default:         lamps = 2'b00;
    endcase
    return lamps;
  endfunction

endpackage

// File: rtl/switch_debounce.sv
// Two-flop synchroniser followed by a debounce counter for one raw switch.
//   clk, rst_n : clock, asynchronous active-low reset
//   sw         : raw asynchronous switch input
//   level      : debounced level
//   rise       : one-cycle pulse, high in the first cycle level reads 1
// The debounced level follows the synchronised input only after it has disagreed
// for DEBOUNCE_CYC consecutive samples; any agreeing sample restarts the count.
module switch_debounce
  import thunderbird_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = cw(DEBOUNCE_CYC);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic            rise_q, rise_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/thunderbird_turn_ctrl.sv
// Front-end controller for the thunderbird tail-light sequencer.
//   Clk, reset          : clock (rising edge), asynchronous active-low reset
//   left_sw, right_sw   : raw turn stalk switches
//   hazard_sw           : raw hazard push button (toggles a latch)
//   left, right         : registered lamp commands to the sequencer
//   step_en             : one-cycle pulse every STEP_DIV cycles while active
//   step_idx            : step within the current sweep
//   busy                : controller is in any state other than idle
// A short stalk press (tap) yields TAP_SWEEPS full sweeps; a long press finishes
// the sweep in progress after release. Hazard overrides everything.
module thunderbird_turn_ctrl
  import thunderbird_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = DEBOUNCE_CYC_DEFAULT,
  parameter int unsigned STEP_DIV     = STEP_DIV_DEFAULT,
  parameter int unsigned SEQ_STEPS    = SEQ_STEPS_DEFAULT,
  parameter int unsigned TAP_SWEEPS   = TAP_SWEEPS_DEFAULT,
  parameter int unsigned TAP_MAX_CYC  = TAP_MAX_CYC_DEFAULT
) (
  input  logic                     Clk,
  input  logic                     reset,
  input  logic                     left_sw,
  input  logic                     right_sw,
  input  logic                     hazard_sw,
  output logic                     left,
  output logic                     right,
  output logic                     step_en,
  output logic [cw(SEQ_STEPS)-1:0] step_idx,
  output logic                     busy
);

  localparam int unsigned PrescW = cw(STEP_DIV);
  localparam int unsigned IdxW   = cw(SEQ_STEPS);
  localparam int unsigned SweepW = cw(TAP_SWEEPS);
  localparam int unsigned HoldW  = cw(TAP_MAX_CYC + 1);

  localparam logic [PrescW-1:0] PrescLast = PrescW'(STEP_DIV - 1);
  localparam logic [IdxW-1:0]   IdxLast   = IdxW'(SEQ_STEPS - 1);
  localparam logic [SweepW-1:0] SweepLast = SweepW'(TAP_SWEEPS - 1);
  localparam logic [HoldW-1:0]  HoldMax   = HoldW'(TAP_MAX_CYC);

  // Conditioned switches
  logic left_db, left_rise;
  logic right_db, right_rise;
  logic haz_db, haz_rise;
  logic unused_haz_level;

  switch_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_left_db (
    .clk  (Clk),
    .rst_n(reset),
    .sw   (left_sw),
    .level(left_db),
    .rise (left_rise)
  );

  switch_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_right_db (
    .clk  (Clk),
    .rst_n(reset),
    .sw   (right_sw),
    .level(right_db),
    .rise (right_rise)
  );

  switch_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_hazard_db (
    .clk  (Clk),
    .rst_n(reset),
    .sw   (hazard_sw),
    .level(haz_db),
    .rise (haz_rise)
  );

  // Only the press edge of the hazard button matters.
  assign unused_haz_level = haz_db;

  // State and registered outputs
  tb_state_e         state_q, state_d;
  logic              haz_latch_q, haz_latch_d;
  logic [PrescW-1:0] presc_q, presc_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [SweepW-1:0] sweep_q, sweep_d;
  logic [HoldW-1:0]  hold_q, hold_d;
  logic              left_q, left_d;
  logic              right_q, right_d;
  logic              step_en_q, step_en_d;
  logic              busy_q, busy_d;

  logic tick;    // prescaler at terminal count in an active state
  logic wrap;    // sweep boundary: step_idx about to return to 0
  logic entry;   // state changes on this edge
  logic holding; // own stalk still held in LEFT/RIGHT

  assign tick    = (state_q != StIdle) && (presc_q == PrescLast);
  assign wrap    = tick && (idx_q == IdxLast);
  assign entry   = (state_d != state_q);
  assign holding = ((state_q == StLeft) && left_db) || ((state_q == StRight) && right_db);

  // Next state
  always_comb begin
    haz_latch_d = haz_latch_q ^ haz_rise;
    state_d     = state_q;
    unique case (state_q)
      StIdle: begin
        // Both stalks held together is a conflict and is ignored.
        if (left_db && !right_db) begin
          state_d = StLeft;
        end else if (right_db && !left_db) begin
          state_d = StRight;
        end
      end
      StLeft: begin
        if (right_rise) begin
          state_d = StRight;
        end else if (!left_db) begin
          if (hold_q < HoldMax) begin
            state_d = StTapL;
          end else if (wrap) begin
            state_d = StIdle;
          end
        end
      end
      StRight: begin
        if (left_rise) begin
          state_d = StLeft;
        end else if (!right_db) begin
          if (hold_q < HoldMax) begin
            state_d = StTapR;
          end else if (wrap) begin
            state_d = StIdle;
          end
        end
      end
      StTapL: begin
        if (left_rise) begin
          state_d = StLeft;
        end else if (right_rise) begin
          state_d = StRight;
        end else if (wrap && (sweep_q == SweepLast)) begin
          state_d = StIdle;
        end
      end
      StTapR: begin
        if (right_rise) begin
          state_d = StRight;
        end else if (left_rise) begin
          state_d = StLeft;
        end else if (wrap && (sweep_q == SweepLast)) begin
          state_d = StIdle;
        end
      end
      // Latch still set is caught by the override below; otherwise leave.
      StHazard: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
    if (haz_latch_d) begin
      state_d = StHazard;
    end
  end

  // Pacing counters and outputs
  always_comb begin
    presc_d   = presc_q;
    idx_d     = idx_q;
    sweep_d   = sweep_q;
    hold_d    = hold_q;
    step_en_d = 1'b0;

    if (entry || (state_d == StIdle)) begin
      presc_d = '0;
      idx_d   = '0;
      sweep_d = '0;
      hold_d  = '0;
    end else begin
      presc_d = (presc_q == PrescLast) ? '0 : presc_q + 1'b1;
      if (tick) begin
        step_en_d = 1'b1;
        idx_d     = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end
      if (wrap && ((state_q == StTapL) || (state_q == StTapR))) begin
        sweep_d = sweep_q + 1'b1;
      end
      if (holding && (hold_q != HoldMax)) begin
        hold_d = hold_q + 1'b1;
      end
    end

    {left_d, right_d} = state_lamps(state_d);
    busy_d            = (state_d != StIdle);
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      haz_latch_q <= 1'b0;
      presc_q     <= '0;
      idx_q       <= '0;
      sweep_q     <= '0;
      hold_q      <= '0;
      left_q      <= 1'b0;
      right_q     <= 1'b0;
      step_en_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      haz_latch_q <= haz_latch_d;
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      sweep_q     <= sweep_d;
      hold_q      <= hold_d;
      left_q      <= left_d;
      right_q     <= right_d;
      step_en_q   <= step_en_d;
      busy_q      <= busy_d;
    end
  end

  assign left     = left_q;
  assign right    = right_q;
  assign step_en  = step_en_q;
  assign step_idx = idx_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_thunderbird_turn_ctrl.sv
// Scoreboard bench for thunderbird_turn_ctrl. Expected output vectors
// {left, right, busy, step_en, step_idx} are queued per clock edge when the
// stimulus is planned and compared on the following falling edge.
module tb_thunderbird_turn_ctrl;

  localparam int STEP_DIV  = 4;
  localparam int SEQ_STEPS = 4;

  logic       Clk = 1'b0;
  logic       reset = 1'b1;
  logic       left_sw = 1'b0;
  logic       right_sw = 1'b0;
  logic       hazard_sw = 1'b0;
  logic       left, right, step_en, busy;
  logic [1:0] step_idx;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct packed {
    int         n;
    logic [5:0] exp;
  } sb_t;

  sb_t   sb[$];
  string sb_tag[$];
  sb_t   mon_e;
  string mon_tag;

  thunderbird_turn_ctrl dut (
    .Clk      (Clk),
    .reset    (reset),
    .left_sw  (left_sw),
    .right_sw (right_sw),
    .hazard_sw(hazard_sw),
    .left     (left),
    .right    (right),
    .step_en  (step_en),
    .step_idx (step_idx),
    .busy     (busy)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [5:0] obs_vec();
    return {left, right, busy, step_en, step_idx};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
  endtask

  // Expected vector i edges after entering an active state.
  function automatic logic [5:0] sweep_vec(input bit l, input bit r, input int i);
    logic [1:0] idx;
    bit         se;
    idx = 2'((i / STEP_DIV) % SEQ_STEPS);
    se  = (i != 0) && (i % STEP_DIV == 0);
    return {l, r, 1'b1, se, idx};
  endfunction

  task automatic push_rng(input string tag, input int from, input int to, input bit active,
                          input int base, input bit l, input bit r);
    sb_t e;
    for (int n = from; n <= to; n++) begin
      e.n   = n;
      e.exp = active ? sweep_vec(l, r, n - base) : 6'd0;
      sb.push_back(e);
      sb_tag.push_back(tag);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge Clk);
      #1;
    end
  endtask

  always @(negedge Clk) begin
    while (sb.size() != 0 && sb[0].n <= cyc) begin
      mon_e   = sb.pop_front();
      mon_tag = sb_tag.pop_front();
      if (mon_e.n == cyc) check_eq(mon_tag, 32'(obs_vec()), 32'(mon_e.exp));
      else check_eq({mon_tag, "_missed"}, cyc, mon_e.n);
    end
  end

  int c0;

  initial begin
    // 1: reset, then quiet idle
    #2 reset = 1'b0;
    #1 check_eq("reset_async_init", 32'(obs_vec()), 0);
    repeat (3) @(posedge Clk);
    #1 reset = 1'b1;
    c0 = cyc;
    push_rng("idle_after_reset", c0 + 1, c0 + 50, 1'b0, 0, 1'b0, 1'b0);
    tick(50);

    // 2: glitchy left, then held; stable rise at c0+10, release at c0+50
    c0 = cyc;
    push_rng("glitch_quiet", c0 + 1, c0 + 16, 1'b0, 0, 1'b0, 1'b0);
    push_rng("left_hold", c0 + 17, c0 + 64, 1'b1, c0 + 17, 1'b1, 1'b0);
    push_rng("left_release_wrap", c0 + 65, c0 + 70, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      left_sw = (i % 2 == 0);
      tick(1);
    end
    left_sw = 1'b1;
    tick(40);
    left_sw = 1'b0;
    tick(20);

    // 3: 8-cycle tap -> LEFT briefly, then TAP_L for three sweeps
    c0 = cyc;
    push_rng("tap_debounce", c0 + 1, c0 + 6, 1'b0, 0, 1'b0, 1'b0);
    push_rng("tap_left", c0 + 7, c0 + 14, 1'b1, c0 + 7, 1'b1, 1'b0);
    push_rng("tap_sweeps", c0 + 15, c0 + 62, 1'b1, c0 + 15, 1'b1, 1'b0);
    push_rng("tap_done", c0 + 63, c0 + 68, 1'b0, 0, 1'b0, 1'b0);
    left_sw = 1'b1;
    tick(8);
    left_sw = 1'b0;
    tick(60);

    // 4 + 5: conflict, left, right preempt, hazard on and off
    c0 = cyc;
    push_rng("conflict_idle", c0 + 1, c0 + 16, 1'b0, 0, 1'b0, 1'b0);
    push_rng("left_after_conflict", c0 + 17, c0 + 31, 1'b1, c0 + 17, 1'b1, 1'b0);
    push_rng("right_preempt", c0 + 32, c0 + 44, 1'b1, c0 + 32, 1'b0, 1'b1);
    push_rng("hazard_on", c0 + 45, c0 + 71, 1'b1, c0 + 45, 1'b1, 1'b1);
    push_rng("hazard_off", c0 + 72, c0 + 90, 1'b0, 0, 1'b0, 1'b0);
    left_sw  = 1'b1;
    right_sw = 1'b1;
    tick(10);
    right_sw = 1'b0;
    tick(15);
    right_sw = 1'b1;
    tick(13);
    hazard_sw = 1'b1;
    tick(10);
    hazard_sw = 1'b0;
    tick(17);
    hazard_sw = 1'b1;
    tick(10);
    hazard_sw = 1'b0;
    left_sw   = 1'b0;
    right_sw  = 1'b0;
    tick(15);

    // 6: reset in the middle of a hazard sweep (step_idx = 2)
    c0 = cyc;
    push_rng("hazard2_debounce", c0 + 1, c0 + 6, 1'b0, 0, 1'b0, 1'b0);
    push_rng("hazard2_sweep", c0 + 7, c0 + 16, 1'b1, c0 + 7, 1'b1, 1'b1);
    hazard_sw = 1'b1;
    tick(10);
    hazard_sw = 1'b0;
    tick(6);
    @(negedge Clk);
    #1 reset = 1'b0;
    #1 check_eq("reset_mid_sweep", 32'(obs_vec()), 0);
    tick(2);
    reset = 1'b1;
    c0 = cyc;
    push_rng("idle_after_reset2", c0 + 1, c0 + 20, 1'b0, 0, 1'b0, 1'b0);
    tick(21);

    check_eq("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
